// File: rtl/psram_read_cache_pkg.sv
// Shared definitions for the PSRAM read cache: bus widths, FSM encoding and
// small helpers used by both the controller and the line store.
package psram_read_cache_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEM_REQ   = 2'd1,
        ST_MEM_DRAIN = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    // A request is a write whenever any byte enable is set.
    function automatic logic is_write(input logic [STRB_W-1:0] strb);
        return |strb;
    endfunction

endpackage

// File: rtl/psram_cache_store.sv
// Direct-mapped line store: one data word, one tag and one valid bit per line.
// Combinational read, one byte-enabled write port, single-cycle bulk invalidate.
module psram_cache_store
    import psram_read_cache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [INDEX_BITS-1:0]        rd_index,
    output logic [DATA_W-1:0]            rd_data,
    output logic [ADDR_W-INDEX_BITS-1:0] rd_tag,
    output logic                         rd_valid,
    input  logic                         wr_en,
    input  logic                         wr_tag_en,
    input  logic [INDEX_BITS-1:0]        wr_index,
    input  logic [ADDR_W-INDEX_BITS-1:0] wr_tag,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [STRB_W-1:0]            wr_be,
    input  logic                         inv_all
);

    localparam int LINES = 2 ** INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS;

    logic [DATA_W-1:0] data_mem_r [LINES];
    logic [TAG_W-1:0]  tag_mem_r  [LINES];
    logic [LINES-1:0]  valid_r;

    assign rd_data  = data_mem_r[rd_index];
    assign rd_tag   = tag_mem_r[rd_index];
    assign rd_valid = valid_r[rd_index];

    // Data and tag arrays: no reset, only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_be[b]) begin
                    data_mem_r[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
            if (wr_tag_en) begin
                tag_mem_r[wr_index] <= wr_tag;
            end
        end
    end

    // Valid bits: invalidate-all takes priority over a same-edge fill.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= {LINES{1'b0}};
        end else if (inv_all) begin
            valid_r <= {LINES{1'b0}};
        end else if (wr_en && wr_tag_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/psram_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of a QSPI PSRAM
// controller. Read hits answer in one cycle; read misses fill the line;
// writes always go through to memory and update the line only on a hit.
module psram_read_cache
    import psram_read_cache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              valid,
    output logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TAG_W = ADDR_W - INDEX_BITS;

    state_t            state_r, state_n;
    logic              ready_r, ready_n;
    logic [DATA_W-1:0] rdata_r, rdata_n;
    logic              mem_valid_r, mem_valid_n;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_n;
    logic [STRB_W-1:0] mem_wstrb_r, mem_wstrb_n;
    logic              flush_pend_r, flush_pend_n;

    logic [ADDR_W-1:0] lookup_addr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic              rd_valid_s;
    logic              hit_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              wr_tag_en_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [STRB_W-1:0] wr_be_s;
    logic              inv_all_s;

    // In IDLE the live CPU address is looked up; afterwards the captured one.
    assign lookup_addr_s = (state_r == ST_IDLE) ? addr : mem_addr_r;
    assign hit_s = rd_valid_s && (rd_tag_s == lookup_addr_s[ADDR_W-1:INDEX_BITS]);

    psram_cache_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk       (clk),
        .resetn    (resetn),
        .rd_index  (lookup_addr_s[INDEX_BITS-1:0]),
        .rd_data   (rd_data_s),
        .rd_tag    (rd_tag_s),
        .rd_valid  (rd_valid_s),
        .wr_en     (wr_en_s),
        .wr_tag_en (wr_tag_en_s),
        .wr_index  (mem_addr_r[INDEX_BITS-1:0]),
        .wr_tag    (mem_addr_r[ADDR_W-1:INDEX_BITS]),
        .wr_data   (wr_data_s),
        .wr_be     (wr_be_s),
        .inv_all   (inv_all_s)
    );

    // Next-state, next-output and store-control decode.
    always_comb begin
        state_n      = state_r;
        ready_n      = ready_r;
        rdata_n      = rdata_r;
        mem_valid_n  = mem_valid_r;
        mem_addr_n   = mem_addr_r;
        mem_wdata_n  = mem_wdata_r;
        mem_wstrb_n  = mem_wstrb_r;
        flush_pend_n = flush_pend_r;
        accept_s     = 1'b0;
        wr_en_s      = 1'b0;
        wr_tag_en_s  = 1'b0;
        wr_data_s    = {DATA_W{1'b0}};
        wr_be_s      = {STRB_W{1'b0}};
        inv_all_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (flush_pend_r) begin
                    // Deferred flush goes first; the lookup waits one cycle.
                    inv_all_s    = 1'b1;
                    flush_pend_n = 1'b0;
                end else if (valid && !is_write(wstrb) && hit_s) begin
                    accept_s = 1'b1;
                    rdata_n  = rd_data_s;
                    ready_n  = 1'b1;
                    state_n  = ST_RESP;
                end else if (valid && !mem_ready) begin
                    // Never raise mem_valid while the controller still holds mem_ready.
                    accept_s    = 1'b1;
                    mem_valid_n = 1'b1;
                    mem_addr_n  = addr;
                    mem_wdata_n = wdata;
                    mem_wstrb_n = wstrb;
                    state_n     = ST_MEM_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
                if (flush && accept_s) begin
                    flush_pend_n = 1'b1;
                end else if (flush) begin
                    inv_all_s = 1'b1;
                end else begin
                    inv_all_s = inv_all_s;
                end
            end
            ST_MEM_REQ: begin
                if (mem_ready) begin
                    mem_valid_n = 1'b0;
                    state_n     = ST_MEM_DRAIN;
                    if (!is_write(mem_wstrb_r)) begin
                        wr_en_s     = 1'b1;
                        wr_tag_en_s = 1'b1;
                        wr_be_s     = {STRB_W{1'b1}};
                        wr_data_s   = mem_rdata;
                        rdata_n     = mem_rdata;
                    end else if (hit_s) begin
                        wr_en_s   = 1'b1;
                        wr_be_s   = mem_wstrb_r;
                        wr_data_s = mem_wdata_r;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end else begin
                    state_n = ST_MEM_REQ;
                end
                if (flush) begin
                    flush_pend_n = 1'b1;
                end else begin
                    flush_pend_n = flush_pend_r;
                end
            end
            ST_MEM_DRAIN: begin
                if (!mem_ready) begin
                    ready_n = 1'b1;
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_MEM_DRAIN;
                end
                if (flush) begin
                    flush_pend_n = 1'b1;
                end else begin
                    flush_pend_n = flush_pend_r;
                end
            end
            ST_RESP: begin
                if (!valid) begin
                    ready_n = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
                if (flush) begin
                    flush_pend_n = 1'b1;
                end else begin
                    flush_pend_n = flush_pend_r;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                ready_n     = 1'b0;
                mem_valid_n = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_wstrb_r  <= {STRB_W{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            ready_r      <= ready_n;
            rdata_r      <= rdata_n;
            mem_valid_r  <= mem_valid_n;
            mem_addr_r   <= mem_addr_n;
            mem_wdata_r  <= mem_wdata_n;
            mem_wstrb_r  <= mem_wstrb_n;
            flush_pend_r <= flush_pend_n;
        end
    end

    assign ready     = ready_r;
    assign rdata     = rdata_r;
    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_psram_read_cache.sv
// Directed bench for psram_read_cache with a behavioural PSRAM controller model.
module tb_psram_read_cache;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [22:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    int tests_run = 0;
    int tests_failed = 0;

    // Controller model state
    logic [31:0] mem_model [logic [22:0]];
    int          req_cnt = 0;
    int          viol_cnt = 0;
    int          mem_lat = 1;
    int          extra_hold = 0;
    int          lat_cnt = 0;
    int          hold_cnt = 0;
    logic        mv_prev = 1'b0;
    logic [22:0] last_addr = 23'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;

    psram_read_cache #(.INDEX_BITS(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .valid     (valid),
        .ready     (ready),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [22:0] a);
        return 32'hA5000000 | {9'h0, a};
    endfunction

    function automatic logic [31:0] mem_get(input logic [22:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return dflt(a);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Controller model: evaluated on the falling edge, away from the DUT's edge.
    always @(negedge clk) begin
        if (!resetn) begin
            mem_ready = 1'b0;
            lat_cnt   = 0;
            hold_cnt  = 0;
            mv_prev   = 1'b0;
        end else begin
            if (mem_valid && !mv_prev && mem_ready) viol_cnt++;
            mv_prev = mem_valid;
            if (mem_ready) begin
                if (!mem_valid) begin
                    if (hold_cnt > 0) hold_cnt--;
                    else mem_ready = 1'b0;
                end
            end else if (mem_valid) begin
                if (lat_cnt < mem_lat) begin
                    lat_cnt++;
                end else begin
                    lat_cnt    = 0;
                    req_cnt++;
                    last_addr  = mem_addr;
                    last_wdata = mem_wdata;
                    last_wstrb = mem_wstrb;
                    if (mem_wstrb == 4'h0) begin
                        mem_rdata = mem_get(mem_addr);
                    end else begin
                        logic [31:0] w;
                        w = mem_get(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_model[mem_addr] = w;
                    end
                    mem_ready = 1'b1;
                    hold_cnt  = extra_hold;
                end
            end
        end
    end

    // One CPU transaction; optionally pulses flush one cycle after valid.
    task automatic cpu_access(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s,
                              input bit fl, output logic [31:0] rd, output int cyc);
        int n;
        @(negedge clk);
        addr = a; wdata = d; wstrb = s; valid = 1'b1;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
            flush = (fl && cyc == 1) ? 1'b1 : 1'b0;
        end
        flush = 1'b0;
        check_eq("resp_seen", {31'h0, ready}, 32'h1);
        rd = rdata;
        valid = 1'b0;
        n = 0;
        while (ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int cyc;
        int base;
        logic [31:0] d5;

        resetn = 1'b0; flush = 1'b0; valid = 1'b0;
        addr = 23'h0; wdata = 32'h0; wstrb = 4'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'h0, ready}, 32'h0);
        check_eq("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_mem_addr", {9'h0, mem_addr}, 32'h0);
        check_eq("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        @(posedge clk); #2 resetn = 1'b1;

        // Read miss then hit
        mem_model[23'h10] = 32'hDEADBEEF;
        base = req_cnt;
        cpu_access(23'h10, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("miss_rdata", rd, 32'hDEADBEEF);
        check_eq("miss_reqs", req_cnt - base, 1);
        base = req_cnt;
        cpu_access(23'h10, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("hit_rdata", rd, 32'hDEADBEEF);
        check_eq("hit_latency", cyc, 1);
        check_eq("hit_no_req", req_cnt - base, 0);

        // Write hit merges the enabled byte into the line
        mem_model[23'h10] = 32'h11223344;
        flush_idle();
        base = req_cnt;
        cpu_access(23'h10, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("refill_rdata", rd, 32'h11223344);
        check_eq("refill_reqs", req_cnt - base, 1);
        base = req_cnt;
        cpu_access(23'h10, 32'h0000AA00, 4'b0010, 1'b0, rd, cyc);
        check_eq("wr_reqs", req_cnt - base, 1);
        check_eq("wr_addr", {9'h0, last_addr}, 32'h10);
        check_eq("wr_wdata", last_wdata, 32'h0000AA00);
        check_eq("wr_wstrb", {28'h0, last_wstrb}, 32'h2);
        base = req_cnt;
        cpu_access(23'h10, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("merged_rdata", rd, 32'h1122AA44);
        check_eq("merged_hit", req_cnt - base, 0);

        // Conflict misses on the same index
        base = req_cnt;
        cpu_access(23'h05, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("conf_a_rdata", rd, 32'hA5000005);
        cpu_access(23'h45, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("conf_b_rdata", rd, 32'hA5000045);
        cpu_access(23'h05, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("conf_a2_rdata", rd, 32'hA5000005);
        check_eq("conf_reqs", req_cnt - base, 3);

        // Non-contiguous byte enables forwarded and merged literally
        d5 = 32'hA5000005;
        base = req_cnt;
        cpu_access(23'h05, 32'h00BBCC00, 4'b0110, 1'b0, rd, cyc);
        check_eq("odd_strb_fwd", {28'h0, last_wstrb}, 32'h6);
        cpu_access(23'h05, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("odd_strb_rdata", rd, (d5 & 32'hFF0000FF) | 32'h00BBCC00);
        check_eq("odd_strb_reqs", req_cnt - base, 1);

        // Write miss does not allocate
        base = req_cnt;
        cpu_access(23'h20, 32'hCAFEF00D, 4'hF, 1'b0, rd, cyc);
        cpu_access(23'h20, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("noalloc_rdata", rd, 32'hCAFEF00D);
        check_eq("noalloc_reqs", req_cnt - base, 2);

        // Flush during a miss, with mem_ready held 3 extra cycles
        cpu_access(23'h03, 32'h0, 4'h0, 1'b0, rd, cyc);
        extra_hold = 3;
        base = req_cnt;
        cpu_access(23'h07, 32'h0, 4'h0, 1'b1, rd, cyc);
        extra_hold = 0;
        check_eq("flush_miss_rdata", rd, 32'hA5000007);
        cpu_access(23'h03, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("flush_reqs", req_cnt - base, 2);
        check_eq("flush_rdata", rd, 32'hA5000003);
        check_eq("no_reassert", viol_cnt, 0);

        // Reset in the middle of a miss
        cpu_access(23'h30, 32'h0, 4'h0, 1'b0, rd, cyc);
        mem_lat = 3;
        @(negedge clk);
        addr = 23'h40; wstrb = 4'h0; valid = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_mem_valid", {31'h0, mem_valid}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'h0, ready}, 32'h0);
        check_eq("mid_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        valid = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b1;
        mem_lat = 1;
        base = req_cnt;
        cpu_access(23'h30, 32'h0, 4'h0, 1'b0, rd, cyc);
        check_eq("post_rst_miss", req_cnt - base, 1);
        check_eq("post_rst_rdata", rd, 32'hA5000030);
        check_eq("final_no_reassert", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/psram_read_cache.md
PSRAM_READ_CACHE -- requirements
Module: psram_read_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, line count = 2**INDEX_BITS one-word lines (legal 2..8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  invalidate all lines (fence.i).
REQ-005 valid  input  1  CPU request.
REQ-006 ready  output  1  CPU response; held until valid drops.
REQ-007 addr  input  23  CPU word address (8Mx32).
REQ-008 wdata  input  32  CPU write data.
REQ-009 wstrb  input  4  byte enables; nonzero = write, zero = read.
REQ-010 rdata  output  32  CPU read data, valid while ready=1.
REQ-011 mem_valid  output  1  request to downstream QSPI PSRAM controller.
REQ-012 mem_ready  input  1  controller completion; held high until mem_valid drops.
REQ-013 mem_addr, mem_wdata, mem_wstrb  output  23/32/4  request payload, stable while mem_valid=1.
REQ-014 mem_rdata  input  32  controller read data, valid with mem_ready.

Function
REQ-015 Direct-mapped, one 32-bit word per line: index = addr[INDEX_BITS-1:0], tag = addr[22:INDEX_BITS], one valid bit per line.
REQ-016 States: IDLE, MEM_REQ, MEM_DRAIN, RESP.
REQ-017 IDLE, valid=1, ready=0, read hit: rdata <= line data, ready <= 1 next edge (1-cycle latency), -> RESP; no mem request.
REQ-018 IDLE, valid=1, read miss or any write: mem_valid <= 1 with mem_addr=addr, mem_wdata=wdata, mem_wstrb=wstrb, -> MEM_REQ.
REQ-019 MEM_REQ, mem_ready=1: mem_valid <= 0; read: line[index] <= mem_rdata, tag written, valid set, rdata <= mem_rdata; write hit: merge wdata bytes per wstrb into line, tag/valid unchanged; write miss: no allocate; -> MEM_DRAIN.
REQ-020 MEM_DRAIN: wait mem_ready=0, then ready <= 1, -> RESP; mem_valid SHALL never reassert while mem_ready=1.
REQ-021 RESP: ready stays 1 until valid=0; then ready <= 0, -> IDLE; next request accepted no earlier than the following cycle.
REQ-022 Hit determination SHALL use addr sampled in IDLE; addr/wdata/wstrb change while valid=1 is a protocol violation, undefined.
REQ-023 flush=1 in IDLE with no request accepted that cycle: clear all valid bits in one cycle; flush in other states, or coincident with an accepted request, SHALL be latched and applied on the next return to IDLE before any lookup.
REQ-024 flush and fill of the same line in one edge: flush wins (line invalid).
REQ-025 Write with wstrb pattern unsupported downstream (e.g. 4'b0110) SHALL be forwarded unchanged; merge uses wstrb literally.

Reset
REQ-026 resetn=0 asynchronously: state IDLE, ready 0, rdata 0, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, all valid bits 0, pending flush 0; data/tag arrays not reset.
REQ-027 Reset mid-transaction abandons it; after release, block issues no mem request until a new valid, and SHALL wait for mem_ready=0 before first mem_valid.

Structure
REQ-028 Shared package SHALL hold state encodings and ADDR_W=23, DATA_W=32.
REQ-029 Tag/data/valid storage SHALL be one sub-module, psram_cache_store (asynchronous read, single write port with byte enables, bulk-invalidate input).

Verification
REQ-030 Reset, read 0x000010 with memory model returning 0xDEADBEEF -> one mem request, rdata=0xDEADBEEF; repeat read -> ready 1 cycle after valid, mem_valid never asserted.
REQ-031 Read 0x000010 (fill 0x11223344), write 0x000010 wstrb=4'b0010 wdata=0x0000AA00 -> mem request with same payload; subsequent read hits, returns 0x1122AA44.
REQ-032 INDEX_BITS=6: read 0x000005 then 0x000045 (same index, different tag) -> both miss; re-read 0x000005 misses again.
REQ-033 Write miss to 0x000020 -> mem write issued; following read of 0x000020 misses (no allocate).
REQ-034 Fill 0x000003, assert flush during a miss to 0x000007 -> after response, read 0x000003 misses; memory model holding mem_ready high 3 extra cycles -> no mem_valid reassertion until mem_ready=0.
REQ-035 Assert resetn=0 while in MEM_REQ -> ready, mem_valid drop immediately; subsequent read of previously filled address misses.
